// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, ExcCode values, field positions
// and the small types used by the exception/interrupt unit.
package cp0_pkg;

    localparam int SIZE_EXCCODE = 4;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam logic [SIZE_EXCCODE:0] EXC_INT  = 5'd0;
    localparam logic [SIZE_EXCCODE:0] EXC_ADEL = 5'd4;
    localparam logic [SIZE_EXCCODE:0] EXC_ADES = 5'd5;
    localparam logic [SIZE_EXCCODE:0] EXC_SYS  = 5'd8;
    localparam logic [SIZE_EXCCODE:0] EXC_RI   = 5'd10;
    localparam logic [SIZE_EXCCODE:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;
    localparam int CAUSE_BD      = 31;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_IPSW_HI = 9;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;

    // One accepted event per cycle, in priority order.
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_EXC  = 2'd1,
        EV_INT  = 2'd2,
        EV_ERET = 2'd3
    } event_e;

    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    // A delay-slot instruction restarts at its branch.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// Pipeline-facing bundle of the CP0 unit: MEM-stage instruction info, MTC0/MFC0
// access, external interrupts and the redirect back to fetch.
interface cp0_if #(
    parameter int EXCW = 5
);
    logic            pc_valid;
    logic [31:0]     pc_in;
    logic            bd_in;
    logic            exc_valid;
    logic [EXCW-1:0] exc_code;
    logic            eret;
    logic            mtc0_we;
    logic [4:0]      reg_addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [5:0]      hw_int;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            exl;

    // Handshake: redirect_valid is a valid-only, one-cycle pulse with no ready;
    // fetch must flush and load redirect_pc in the cycle it is seen.
    modport master (
        output pc_valid, pc_in, bd_in, exc_valid, exc_code, eret,
        output mtc0_we, reg_addr, wdata, hw_int,
        input  rdata, redirect_valid, redirect_pc, exl
    );

    modport slave (
        input  pc_valid, pc_in, bd_in, exc_valid, exc_code, eret,
        input  mtc0_we, reg_addr, wdata, hw_int,
        output rdata, redirect_valid, redirect_pc, exl
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock and TI is raised when
// an increment lands on Compare.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic        ti_clear,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    logic        tick_q;
    logic [31:0] count_inc;
    logic        hit;

    assign count_inc = count + 32'd1;
    // Only a real increment can match; a write to Count suppresses it.
    assign hit = tick_q & ~count_we & (count_inc == compare);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q  <= 1'b0;
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (count_we)
                count <= wdata;
            else if (tick_q)
                count <= count_inc;
            if (compare_we)
                compare <= wdata;
            if (ti_clear)
                ti <= 1'b0;
            else if (hit)
                ti <= 1'b1;
        end
    end
endmodule

// File: rtl/cp0.sv
// Coprocessor-0 exception/interrupt unit: Status, Cause, EPC, the event priority
// and the registered redirect to fetch; the timer lives in cp0_timer.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          EXCW       = SIZE_EXCCODE + 1
) (
    input logic  clk,
    input logic  rst,
    cp0_if.slave bus
);
    status_t         status_q;
    logic            bd_q;
    logic [5:0]      hw_q;
    logic [1:0]      ip_sw_q;
    logic [EXCW-1:0] exc_code_q;
    logic [31:0]     epc_q;
    logic            redirect_valid_q;
    logic [31:0]     redirect_pc_q;

    logic [31:0]     count;
    logic [31:0]     compare;
    logic            ti;

    logic [7:0]      ip;
    logic            int_pending;
    event_e          ev;
    logic            wr_en;
    logic            wr_count;
    logic            wr_compare;
    logic [31:0]     rdata;

    assign ip          = {ti | hw_q[5], hw_q[4:0], ip_sw_q};
    assign int_pending = status_q.ie & ~status_q.exl & (|(ip & status_q.im));

    always_comb begin
        ev = EV_NONE;
        if (bus.pc_valid & bus.exc_valid)
            ev = EV_EXC;
        else if (bus.pc_valid & int_pending)
            ev = EV_INT;
        else if (bus.pc_valid & bus.eret)
            ev = EV_ERET;
    end

    // MTC0 only lands in a cycle with no higher-priority event.
    assign wr_en      = bus.mtc0_we & (ev == EV_NONE);
    assign wr_count   = wr_en & (bus.reg_addr == REG_COUNT);
    assign wr_compare = wr_en & (bus.reg_addr == REG_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .ti_clear   (wr_compare),
        .wdata      (bus.wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= '0;
            bd_q       <= 1'b0;
            hw_q       <= 6'd0;
            ip_sw_q    <= 2'd0;
            exc_code_q <= '0;
            epc_q      <= 32'd0;
        end else begin
            hw_q <= bus.hw_int;
            case (ev)
                EV_EXC, EV_INT: begin
                    exc_code_q <= (ev == EV_EXC) ? bus.exc_code : EXCW'(EXC_INT);
                    // Nested exceptions keep the original return point.
                    if (!status_q.exl) begin
                        epc_q <= epc_of(bus.pc_in, bus.bd_in);
                        bd_q  <= bus.bd_in;
                    end
                    status_q.exl <= 1'b1;
                end
                EV_ERET: status_q.exl <= 1'b0;
                default: begin
                    if (wr_en) begin
                        case (bus.reg_addr)
                            REG_STATUS: begin
                                status_q.im  <= bus.wdata[STATUS_IM_HI:STATUS_IM_LO];
                                status_q.exl <= bus.wdata[STATUS_EXL];
                                status_q.ie  <= bus.wdata[STATUS_IE];
                            end
                            REG_CAUSE: ip_sw_q <= bus.wdata[CAUSE_IPSW_HI:CAUSE_IP_LO];
                            REG_EPC:   epc_q   <= bus.wdata;
                            default:   ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            redirect_valid_q <= (ev != EV_NONE);
            if (ev == EV_ERET)
                redirect_pc_q <= epc_q;
            else if (ev != EV_NONE)
                redirect_pc_q <= EXC_VECTOR;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (bus.reg_addr)
            REG_COUNT:   rdata = count;
            REG_COMPARE: rdata = compare;
            REG_STATUS:  rdata = {16'd0, status_q.im, 6'd0, status_q.exl, status_q.ie};
            REG_CAUSE:   rdata = {bd_q, ti, 14'd0, ip, 1'b0, exc_code_q, 2'd0};
            REG_EPC:     rdata = epc_q;
            default:     rdata = 32'd0;
        endcase
    end

    assign bus.rdata          = rdata;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.exl            = status_q.exl;
endmodule
